sda_action_ctrl_regfile: RTL
============================

Name: sda_action_ctrl_regfile

Overview:
Host-facing control and parameter register file that sits on the other end of a kernel action's control and parameter channels. It is an AXI4-Lite slave that the host uses to load parameter words and to start the action. It drives the go request and accepts the done token. It answers the action's parameter-address requests with data from the register file. It instantiates beside the teak action top and connects port-for-port to the action's go/done, paramaddr and paramdata channels.

Parameters:
NUM_PARAMS, 16, number of 32-bit parameter registers (1..64).
PARAM_BASE, 32'h10, byte offset of parameter word 0 in the AXI-Lite map.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_axi_araddr/arvalid/arready, rdata/rresp/rvalid/rready  in/in/out, out/out/out/in  32/1/1, 32/2/1/1  AXI-Lite read channels
s_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  in/in/out, in/in/in/out, out/out/in  32/1/1, 32/4/1/1, 2/1/1  AXI-Lite write channels
s_axi_arcache/arprot/awcache/awprot  in  4/3/4/3  ignored
go_0r  out  1  go request to action
go_0a  in  1  go accept from action
done_0r  in  1  done request from action
done_0a  out  1  done accept to action
paramaddr_0r0  in  1  parameter index valid from action
paramaddr_0D  in  32  parameter word index
paramaddr_0a  out  1  parameter index accept
paramdata_0r0  out  1  parameter data valid
paramdata_0D  out  32  parameter data
paramdata_0a  in  1  parameter data accept

Behaviour:
- Reset is synchronous and active-high on clk; clock is clk. During reset, all outputs are 0, all parameter registers are 0, the FSMs go to IDLE, and the done sticky bit is 0. Reset mid-operation abandons any in-flight go, done, AXI or parameter transaction.
- All channel pairs (r/a, valid/ready) are synchronous. A transfer occurs in the cycle where both are high. A request, once raised, is held with stable data until it transfers.
- Register map (byte address; only the low 8 bits are decoded):
  - 0x00 CTRL.
    - Write with bit0=1 starts the action (ignored unless the FSM is IDLE).
    - Read: bit0=busy, bit1=done sticky, bit2=idle.
  - PARAM_BASE+4n: PARAM[n], read/write.
  - All other addresses read 0 with OKAY, and writes to them are dropped with OKAY.
- AXI write:
  - When awvalid&wvalid are both seen, awready and wready pulse together one cycle later.
  - bvalid rises the following cycle and holds until bready.
  - No new write is accepted while bvalid is high.
  - wstrb is applied per byte to PARAM writes.
  - A PARAM write while the FSM is not IDLE is dropped with bresp=2'b10 (SLVERR); otherwise bresp=2'b00.
- AXI read:
  - arready pulses one cycle after arvalid is seen.
  - rvalid with rdata rises the next cycle and holds until rready.
  - Data is captured at the arready cycle. rresp is always 2'b00.
  - Reading CTRL clears the done sticky bit in the arready cycle. A done transfer in that same cycle wins: the bit ends up set, and the read returns the value from before the done.
- Main FSM:
  - IDLE -> GO on a start write. go_0r=1 in GO.
  - GO -> RUN on go_0r&go_0a. done_0a=1 in RUN only.
  - RUN -> IDLE on done_0r&done_0a; the done sticky bit is set in that cycle.
  - done_0r outside RUN is not accepted.
  - busy = (GO|RUN); idle = IDLE.
- Parameter responder:
  - paramaddr_0a=1 whenever no data is pending.
  - On an address transfer in cycle T: paramdata_0r0=1 from T+1, with paramdata_0D=PARAM[index] captured at T. It holds until paramdata_0a, after which paramaddr_0a returns to 1 the next cycle.
  - Index >= NUM_PARAMS returns 32'h0.
  - One request is outstanding at most.

Optional Feature:
SDA_ACTION_CTRL_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, reset 0).
  - 0x04 IER: bit0 enables the interrupt.
  - 0x08 ISR: bit0 is set on the done transfer; writing 1 to bit0 clears it (write-1-to-toggle is not used).
  - irq = IER[0] & ISR[0], registered.
- Undefined: there is no irq port, and 0x04/0x08 read 0 and ignore writes.

Test Plan:
- Write PARAM[0]=32'hDEADBEEF and PARAM[3]=32'h12345678 with wstrb=4'hF -> reads return the same values, bresp=0. A write with wstrb=4'h1 of 32'h000000AA to PARAM[0] -> reads back 32'hDEADBEAA.
- Write CTRL=1 with go_0a tied 0 for 5 cycles -> go_0r held high, CTRL reads 32'h1. Then go_0a=1 -> go_0r drops the next cycle and done_0a=1.
- While RUN: write PARAM[1]=5 -> bresp=2'b10 and PARAM[1] unchanged. Then done_0r=1 -> done_0a drops and CTRL reads 32'h6. A second read of CTRL -> 32'h4.
- Action sends paramaddr index 3 with paramdata_0a held 0 for 4 cycles -> paramdata_0r0=1 with 32'h12345678 held and paramaddr_0a=0. Index 99 -> data 32'h0.
- Assert reset during RUN -> next cycle all outputs are 0, CTRL reads 32'h4, and PARAM[0] reads 0.
- Irq feature (when SDA_ACTION_CTRL_IRQ_EN is defined): IER=1, run to done -> irq=1. Writing 1 to ISR clears irq the following cycle.

Source files
------------

// File: rtl/sda_action_ctrl_regfile.sv
// rtl/sda_action_ctrl_regfile.sv - AXI-Lite control/parameter register file driving an action's go/done and paramaddr/paramdata channels
// Optional interrupt (IER/ISR at 0x04/0x08, irq port) enabled by defining SDA_ACTION_CTRL_IRQ_EN.
module sda_action_ctrl_regfile #(
  parameter int          NUM_PARAMS = 16,
  parameter logic [31:0] PARAM_BASE = 32'h10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  output logic        go_0r,
  input  logic        go_0a,
  input  logic        done_0r,
  output logic        done_0a,
  input  logic        paramaddr_0r0,
  input  logic [31:0] paramaddr_0D,
  output logic        paramaddr_0a,
  output logic        paramdata_0r0,
  output logic [31:0] paramdata_0D,
  input  logic        paramdata_0a
`ifdef SDA_ACTION_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {IDLE, GO, RUN} state_t;

  state_t      state;
  logic [31:0] params [NUM_PARAMS];
  logic        done_sticky;
  logic [7:0]  wa, ra;
  logic        wr_fire, rd_fire, done_fire, pa_fire, pd_fire;
  logic        wr_param_hit;
  logic [31:0] rd_value, pd_value;
  logic        unused_ok;

  assign wa        = s_axi_awaddr[7:0];
  assign ra        = s_axi_araddr[7:0];
  assign wr_fire   = s_axi_awvalid & s_axi_awready & s_axi_wvalid & s_axi_wready;
  assign rd_fire   = s_axi_arvalid & s_axi_arready;
  assign done_fire = done_0r & done_0a;
  assign pa_fire   = paramaddr_0r0 & paramaddr_0a;
  assign pd_fire   = paramdata_0r0 & paramdata_0a;
  assign s_axi_rresp = 2'b00;
  assign unused_ok = ^{s_axi_arcache, s_axi_arprot, s_axi_awcache, s_axi_awprot,
                       s_axi_araddr[31:8], s_axi_awaddr[31:8]};

  // Only the low address byte is decoded, so the parameter window wraps within 256 bytes.
  function automatic logic [7:0] param_off(input int i);
    return 8'(PARAM_BASE + 32'(4 * i));
  endfunction

`ifdef SDA_ACTION_CTRL_IRQ_EN
  logic ier, isr;
`endif

  always_comb begin
    rd_value = '0;
    if (ra == 8'h00) rd_value = {29'b0, state == IDLE, done_sticky, state != IDLE};
`ifdef SDA_ACTION_CTRL_IRQ_EN
    else if (ra == 8'h04) rd_value = {31'b0, ier};
    else if (ra == 8'h08) rd_value = {31'b0, isr};
`endif
    for (int i = 0; i < NUM_PARAMS; i++)
      if (ra == param_off(i)) rd_value = params[i];
  end

  always_comb begin
    wr_param_hit = 1'b0;
    for (int i = 0; i < NUM_PARAMS; i++)
      if (wa == param_off(i)) wr_param_hit = 1'b1;
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    pd_value = '0;
    for (int i = 0; i < NUM_PARAMS; i++)
      if (paramaddr_0D == 32'(i)) pd_value = params[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) params[i] <= '0;
    end else if (wr_fire && state == IDLE) begin
      for (int i = 0; i < NUM_PARAMS; i++)
        if (wa == param_off(i))
          for (int b = 0; b < 4; b++)
            if (s_axi_wstrb[b]) params[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
    end else begin
      if (s_axi_awvalid && s_axi_wvalid && !s_axi_awready && !s_axi_bvalid) begin
        s_axi_awready <= 1'b1;
        s_axi_wready  <= 1'b1;
      end else begin
        s_axi_awready <= 1'b0;
        s_axi_wready  <= 1'b0;
      end
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= (wr_param_hit && state != IDLE) ? 2'b10 : 2'b00;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_arready <= s_axi_arvalid && !s_axi_arready && !s_axi_rvalid;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_value;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  // A done transfer outranks the read-clear of the sticky bit in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      go_0r       <= 1'b0;
      done_0a     <= 1'b0;
      done_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: if (wr_fire && wa == 8'h00 && s_axi_wdata[0]) begin
          state <= GO;
          go_0r <= 1'b1;
        end
        GO: if (go_0r && go_0a) begin
          state   <= RUN;
          go_0r   <= 1'b0;
          done_0a <= 1'b1;
        end
        RUN: if (done_fire) begin
          state   <= IDLE;
          done_0a <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          go_0r   <= 1'b0;
          done_0a <= 1'b0;
        end
      endcase
      if (done_fire) done_sticky <= 1'b1;
      else if (rd_fire && ra == 8'h00) done_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      paramaddr_0a  <= 1'b0;
      paramdata_0r0 <= 1'b0;
      paramdata_0D  <= '0;
    end else if (pa_fire) begin
      paramaddr_0a  <= 1'b0;
      paramdata_0r0 <= 1'b1;
      paramdata_0D  <= pd_value;
    end else if (pd_fire) begin
      paramdata_0r0 <= 1'b0;
      paramaddr_0a  <= 1'b1;
    end else if (!paramdata_0r0) begin
      paramaddr_0a  <= 1'b1;
    end
  end

`ifdef SDA_ACTION_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ier <= 1'b0;
      isr <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_fire && wa == 8'h04) ier <= s_axi_wdata[0];
      if (done_fire) isr <= 1'b1;
      else if (wr_fire && wa == 8'h08 && s_axi_wdata[0]) isr <= 1'b0;
      irq <= ier & isr;
    end
  end
`endif

endmodule
